// File: rtl/arm_hazard_pkg.sv
// Shared types and constants for the ARM pipeline hazard/forwarding controller.
package arm_hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    localparam int PC_REG = 15;

endpackage

// File: rtl/arm_hazard_busy_ctr.sv
// Occupancy counter for the multi-cycle execute unit: loads on an accepted
// start, counts down while not frozen by a memory stall.
module hazard_busy_ctr #(
    parameter int MUL_LAT = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_freeze,
    output logic o_busy,
    output logic o_hold
);

    localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(MUL_LAT - 1);

    logic [CW-1:0] r_cnt;
    logic          w_busy;

    assign w_busy = (r_cnt != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!i_freeze) begin
            if (w_busy) begin
                r_cnt <= r_cnt - 1'b1;
            end else if (i_start) begin
                r_cnt <= LOAD_VAL;
            end
        end
    end

    // On the last busy cycle the op completes, so E is released rather than held.
    assign o_busy = w_busy;
    assign o_hold = (r_cnt > CW'(1));

endmodule

// File: rtl/arm_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage ARM pipeline.
// Optional ARM_HAZARD_PERF_EN adds saturating stall/flush performance counters.
module arm_hazard_ctrl
    import arm_hazard_pkg::*;
#(
    parameter int REG_AW      = 4,
    parameter int MUL_LAT     = 3,
    parameter int MEM_TIMEOUT = 64,
    parameter int TO_W        = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Ra1D,
    input  logic [REG_AW-1:0] Ra2D,
    input  logic [REG_AW-1:0] Ra1E,
    input  logic [REG_AW-1:0] Ra2E,
    input  logic [REG_AW-1:0] Wa3E,
    input  logic [REG_AW-1:0] Wa3M,
    input  logic [REG_AW-1:0] Wa3W,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemToRegE,
    input  logic              BranchTakenE,
    input  logic              MulStartE,
    input  logic              MemReqM,
    input  logic              MemReadyM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic              MemErr
`ifdef ARM_HAZARD_PERF_EN
    ,
    output logic [31:0]       StallCycles,
    output logic [31:0]       FlushCount
`endif
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    logic            w_mem_stall;
    logic            w_busy;
    logic            w_hold;
    logic            w_mul_stall;
    logic            w_ld_stall;
    fwd_sel_e        w_fwd_a;
    fwd_sel_e        w_fwd_b;
    logic [TO_W-1:0] r_wait_cnt;
    logic            r_mem_err;

    function automatic fwd_sel_e fwd_sel(
        input logic [REG_AW-1:0] ra,
        input logic [REG_AW-1:0] wm,
        input logic [REG_AW-1:0] ww,
        input logic              rwm,
        input logic              rww
    );
        fwd_sel_e sel;
        sel = FWD_RF;
        // The PC reads its own datapath value and must never be bypassed.
        if ((REG_AW == 4) && (32'(ra) == PC_REG)) begin
            sel = FWD_RF;
        end else if (rwm && (wm == ra)) begin
            sel = FWD_M;
        end else if (rww && (ww == ra)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

    assign w_fwd_a     = fwd_sel(Ra1E, Wa3M, Wa3W, RegWriteM, RegWriteW);
    assign w_fwd_b     = fwd_sel(Ra2E, Wa3M, Wa3W, RegWriteM, RegWriteW);
    assign w_mem_stall = MemReqM && !MemReadyM;

    hazard_busy_ctr #(
        .MUL_LAT (MUL_LAT)
    ) u_busy (
        .i_clk    (clk),
        .i_rst_n  (rst),
        .i_start  (MulStartE),
        .i_freeze (w_mem_stall),
        .o_busy   (w_busy),
        .o_hold   (w_hold)
    );

    assign w_mul_stall = w_hold || (MulStartE && !w_busy && (MUL_LAT > 1));
    assign w_ld_stall  = MemToRegE && ((Wa3E == Ra1D) || (Wa3E == Ra2D)) && !w_busy;

    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        if (!rst) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else begin
            ForwardAE = w_fwd_a;
            ForwardBE = w_fwd_b;
            if (w_mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (w_mul_stall) begin
                // M keeps advancing; the caller inserts a bubble into M.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
            end else if (BranchTakenE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (w_ld_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else if (w_mem_stall) begin
            if (r_wait_cnt != '1) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (r_wait_cnt == TO_LAST) begin
                r_mem_err <= 1'b1;
            end
        end else begin
            r_wait_cnt <= '0;
        end
    end

    assign MemErr = r_mem_err;

`ifdef ARM_HAZARD_PERF_EN
    logic        w_branch_flush;
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    assign w_branch_flush = rst && BranchTakenE && !w_mem_stall && !w_mul_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (StallF && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_branch_flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    assign StallCycles = r_stall_cycles;
    assign FlushCount  = r_flush_count;
`endif

    logic w_unused;
    assign w_unused = RegWriteE;

endmodule

// File: tb/tb_arm_hazard_ctrl.sv
// Directed plus randomized check of arm_hazard_ctrl against a cycle-level model.
module tb_arm_hazard_ctrl;

    localparam int REG_AW      = 4;
    localparam int MUL_LAT     = 3;
    localparam int MEM_TIMEOUT = 4;
    localparam int TO_W        = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] Ra1D, Ra2D, Ra1E, Ra2E, Wa3E, Wa3M, Wa3W;
    logic       RegWriteE, RegWriteM, RegWriteW, MemToRegE, BranchTakenE;
    logic       MulStartE, MemReqM, MemReadyM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
`ifdef ARM_HAZARD_PERF_EN
    logic [31:0] StallCycles, FlushCount;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: remaining cycles the multiplier is occupied after its start
    // cycle, length of the current memory-wait run, sticky error.
    int mul_left = 0;
    int wait_run = 0;
    bit err      = 1'b0;

    arm_hazard_ctrl #(
        .REG_AW      (REG_AW),
        .MUL_LAT     (MUL_LAT),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (TO_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .Ra1D         (Ra1D),
        .Ra2D         (Ra2D),
        .Ra1E         (Ra1E),
        .Ra2E         (Ra2E),
        .Wa3E         (Wa3E),
        .Wa3M         (Wa3M),
        .Wa3W         (Wa3W),
        .RegWriteE    (RegWriteE),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .MemToRegE    (MemToRegE),
        .BranchTakenE (BranchTakenE),
        .MulStartE    (MulStartE),
        .MemReqM      (MemReqM),
        .MemReadyM    (MemReadyM),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushW       (FlushW),
        .MemErr       (MemErr)
`ifdef ARM_HAZARD_PERF_EN
        ,
        .StallCycles  (StallCycles),
        .FlushCount   (FlushCount)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] exp_fwd(input int ra, input int wm, input int ww,
                                           input bit rwm, input bit rww);
        if (ra == 15) return 2'b00;
        if (rwm && wm == ra) return 2'b10;
        if (rww && ww == ra) return 2'b01;
        return 2'b00;
    endfunction

    // {FwdA, FwdB, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr}
    function automatic logic [11:0] expected();
        bit mem, mul_stall, ld;
        logic [1:0] fa, fb;
        if (!rst) return 12'b0000_0000_1110;
        fa = exp_fwd(int'(Ra1E), int'(Wa3M), int'(Wa3W), RegWriteM, RegWriteW);
        fb = exp_fwd(int'(Ra2E), int'(Wa3M), int'(Wa3W), RegWriteM, RegWriteW);
        mem       = MemReqM && !MemReadyM;
        mul_stall = (mul_left > 1) || (MulStartE && mul_left == 0 && MUL_LAT > 1);
        ld        = MemToRegE && (Wa3E == Ra1D || Wa3E == Ra2D) && mul_left == 0;
        if (mem)            return {fa, fb, 4'b1111, 3'b001, err};
        else if (mul_stall) return {fa, fb, 4'b1110, 3'b000, err};
        else if (BranchTakenE) return {fa, fb, 4'b0000, 3'b110, err};
        else if (ld)        return {fa, fb, 4'b1100, 3'b010, err};
        return {fa, fb, 4'b0000, 3'b000, err};
    endfunction

    task automatic model_clear();
        mul_left = 0;
        wait_run = 0;
        err      = 1'b0;
    endtask

    task automatic model_edge();
        bit mem;
        if (!rst) begin
            model_clear();
            return;
        end
        mem = MemReqM && !MemReadyM;
        if (mem) begin
            wait_run++;
            if (wait_run >= MEM_TIMEOUT) err = 1'b1;
        end else begin
            wait_run = 0;
            if (mul_left > 0) mul_left--;
            else if (MulStartE) mul_left = MUL_LAT - 1;
        end
    endtask

    task automatic compare(input string tag);
        logic [11:0] obs, exp;
        obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW, MemErr};
        exp = expected();
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
        end
        $display("step %-20s obs=%03h exp=%03h", tag, obs, exp);
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        compare(tag);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic async_reset();
        #2 rst = 1'b0;
        model_clear();
        #1 compare("async_rst_held");
        rst = 1'b1;
    endtask

    task automatic idle();
        {Ra1D, Ra2D, Ra1E, Ra2E} = {4'd1, 4'd2, 4'd6, 4'd7};
        {Wa3E, Wa3M, Wa3W}       = {4'd8, 4'd9, 4'd10};
        {RegWriteE, RegWriteM, RegWriteW, MemToRegE} = 4'b0;
        {BranchTakenE, MulStartE, MemReqM}           = 3'b0;
        MemReadyM = 1'b1;
    endtask

    function automatic logic [3:0] rreg();
        return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    endfunction

    initial begin
        idle();
        rst = 1'b0;
        RegWriteM = 1'b1; Wa3M = 4'd3; Ra1E = 4'd3; BranchTakenE = 1'b1;
        step("reset_hold_0");
        step("reset_hold_1");
        rst = 1'b1;
        idle();

        RegWriteM = 1'b1; Wa3M = 4'd3; RegWriteW = 1'b1; Wa3W = 4'd3; Ra1E = 4'd3;
        step("fwd_a_m_priority");
        RegWriteM = 1'b0;
        step("fwd_a_w");
        Ra1E = 4'd4;
        step("fwd_a_rf");
        RegWriteM = 1'b1; Ra2E = 4'd3;
        step("fwd_b_m");
        Ra1E = 4'd15; Ra2E = 4'd15; Wa3M = 4'd15; Wa3W = 4'd15;
        step("fwd_pc_never");
        idle();

        MemToRegE = 1'b1; Wa3E = 4'd5; Ra2D = 4'd5;
        step("load_use");
        idle();
        step("load_use_after");

        MemToRegE = 1'b1; Wa3E = 4'd5; Ra1D = 4'd5; BranchTakenE = 1'b1;
        step("branch_vs_load_use");
        idle();

        MulStartE = 1'b1;
        step("mul_start");
        step("mul_busy_restart");
        step("mul_last_ignored");
        MulStartE = 1'b0;
        step("mul_done");

        MemReqM = 1'b1; MemReadyM = 1'b0; BranchTakenE = 1'b1;
        for (int i = 0; i < 3; i++) step("mem_wait_branch");
        MemReadyM = 1'b1;
        step("mem_release_branch");
        idle();

        MulStartE = 1'b1;
        step("mul_then_mem");
        MulStartE = 1'b0; MemReqM = 1'b1; MemReadyM = 1'b0;
        step("mem_freezes_mul");
        step("mem_freezes_mul");
        MemReadyM = 1'b1;
        step("mul_resumes");
        step("mul_resumes_end");
        idle();

        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int i = 0; i < 6; i++) step("timeout_wait");
        MemReadyM = 1'b1;
        step("err_sticky_0");
        step("err_sticky_1");
        async_reset();
        step("err_cleared");
        idle();

        MulStartE = 1'b1;
        step("mul_before_rst");
        MulStartE = 1'b0;
        async_reset();
        step("mul_cleared_by_rst");

        for (int n = 0; n < 400; n++) begin
            rst          = ($urandom_range(0, 59) != 0);
            Ra1D         = rreg();
            Ra2D         = rreg();
            Ra1E         = rreg();
            Ra2E         = rreg();
            Wa3E         = rreg();
            Wa3M         = rreg();
            Wa3W         = rreg();
            RegWriteE    = 1'($urandom_range(0, 1));
            RegWriteM    = 1'($urandom_range(0, 1));
            RegWriteW    = 1'($urandom_range(0, 1));
            MemToRegE    = ($urandom_range(0, 2) == 0);
            BranchTakenE = ($urandom_range(0, 5) == 0);
            MulStartE    = ($urandom_range(0, 7) == 0);
            MemReqM      = ($urandom_range(0, 3) == 0);
            MemReadyM    = 1'($urandom_range(0, 1));
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
